// File: rtl/lsb_word_serializer.sv
// Parallel-to-serial feeder for the LSB-first mod-5 residue checker: clear pulse, W bits, done.
// Optional golden residue output `exp_residue` is enabled by defining SERIALIZER_CHECK_EN.
module lsb_word_serializer #(
    parameter int W  = 10,
    parameter int CW = $clog2(W + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] data_in,
    input  logic         abort,
    output logic         ready,
    output logic         clr_out,
    output logic         bit_out,
    output logic         bit_valid,
    output logic         last,
    output logic         done
`ifdef SERIALIZER_CHECK_EN
    ,
    output logic [2:0]   exp_residue
`endif
);

    typedef enum logic [1:0] {IDLE, CLR, SHIFT, DONE} state_t;

    state_t        state, state_nx;
    logic [W-1:0]  sr, sr_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          ready_nx, clr_nx, bit_nx, valid_nx, last_nx, done_nx;
    logic          accept;

    // ready is only ever high in IDLE, but stays low for the flush cycle after an abort
    assign accept = (state == IDLE) && ready && load;

    always_comb begin
        state_nx = state;
        sr_nx    = sr;
        cnt_nx   = cnt;
        ready_nx = 1'b0;
        clr_nx   = 1'b0;
        bit_nx   = 1'b0;
        valid_nx = 1'b0;
        last_nx  = 1'b0;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = CLR;
                    sr_nx    = data_in;
                    cnt_nx   = CW'(W);
                    clr_nx   = 1'b1;
                end else begin
                    ready_nx = 1'b1;
                end
            end
            CLR: begin
                if (abort) begin
                    state_nx = IDLE;
                    sr_nx    = '0;
                    cnt_nx   = '0;
                    clr_nx   = 1'b1;
                end else begin
                    state_nx = SHIFT;
                    valid_nx = 1'b1;
                    bit_nx   = sr[0];
                    last_nx  = (cnt == CW'(1));
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_nx = IDLE;
                    sr_nx    = '0;
                    cnt_nx   = '0;
                    clr_nx   = 1'b1;
                end else begin
                    sr_nx  = sr >> 1;
                    cnt_nx = cnt - CW'(1);
                    if (cnt_nx == '0) begin
                        state_nx = DONE;
                        done_nx  = 1'b1;
                    end else begin
                        valid_nx = 1'b1;
                        bit_nx   = sr_nx[0];
                        last_nx  = (cnt_nx == CW'(1));
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
                ready_nx = 1'b1;
            end
            default: begin
                state_nx = IDLE;
                ready_nx = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            sr        <= '0;
            cnt       <= '0;
            ready     <= 1'b1;
            clr_out   <= 1'b0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            last      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            sr        <= sr_nx;
            cnt       <= cnt_nx;
            ready     <= ready_nx;
            clr_out   <= clr_nx;
            bit_out   <= bit_nx;
            bit_valid <= valid_nx;
            last      <= last_nx;
            done      <= done_nx;
        end
    end

`ifdef SERIALIZER_CHECK_EN
    // MSB-first Horner reduction: r = (2r + b) mod 5 keeps every step within 4 bits
    function automatic logic [2:0] mod5(input logic [W-1:0] v);
        logic [2:0] r;
        logic [3:0] t;
        r = 3'd0;
        for (int i = W - 1; i >= 0; i--) begin
            t = {r, 1'b0} + {3'b000, v[i]};
            r = (t >= 4'd5) ? 3'(t - 4'd5) : t[2:0];
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (reset)
            exp_residue <= 3'd0;
        else if (accept)
            exp_residue <= mod5(data_in);
    end
`endif

endmodule

// File: tb/tb_lsb_word_serializer.sv
// Directed bench for lsb_word_serializer: W=10, W=5 and W=1 instances with a behavioural
// LSB-first mod-5 downstream model per instance.
module tb_lsb_word_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] dbus;
    logic [2:0] ld;
    logic       abort;

    logic       rdy[3], clr[3], bo[3], bv[3], lst[3], dn[3];
`ifdef SERIALIZER_CHECK_EN
    logic [2:0] er[3];
`endif

    int res[3], wt[3];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lsb_word_serializer #(.W(10)) u10 (
        .clk(clk), .reset(rst), .load(ld[0]), .data_in(dbus), .abort(abort),
        .ready(rdy[0]), .clr_out(clr[0]), .bit_out(bo[0]), .bit_valid(bv[0]),
        .last(lst[0]), .done(dn[0])
`ifdef SERIALIZER_CHECK_EN
        , .exp_residue(er[0])
`endif
    );

    lsb_word_serializer #(.W(5)) u5 (
        .clk(clk), .reset(rst), .load(ld[1]), .data_in(dbus[4:0]), .abort(1'b0),
        .ready(rdy[1]), .clr_out(clr[1]), .bit_out(bo[1]), .bit_valid(bv[1]),
        .last(lst[1]), .done(dn[1])
`ifdef SERIALIZER_CHECK_EN
        , .exp_residue(er[1])
`endif
    );

    lsb_word_serializer #(.W(1)) u1 (
        .clk(clk), .reset(rst), .load(ld[2]), .data_in(dbus[0:0]), .abort(1'b0),
        .ready(rdy[2]), .clr_out(clr[2]), .bit_out(bo[2]), .bit_valid(bv[2]),
        .last(lst[2]), .done(dn[2])
`ifdef SERIALIZER_CHECK_EN
        , .exp_residue(er[2])
`endif
    );

    // downstream residue machine: accumulates bit*2^i mod 5, cleared by clr_out
    always @(posedge clk) begin
        for (int s = 0; s < 3; s++) begin
            if (rst || clr[s]) begin
                res[s] <= 0;
                wt[s]  <= 1;
            end else if (bv[s]) begin
                res[s] <= (res[s] + (bo[s] ? wt[s] : 0)) % 5;
                wt[s]  <= (wt[s] * 2) % 5;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input int s);
        chk("rst_ready", 32'(rdy[s]), 1);
        chk("rst_clr", 32'(clr[s]), 0);
        chk("rst_bit", 32'(bo[s]), 0);
        chk("rst_valid", 32'(bv[s]), 0);
        chk("rst_last", 32'(lst[s]), 0);
        chk("rst_done", 32'(dn[s]), 0);
`ifdef SERIALIZER_CHECK_EN
        chk("rst_exp_res", 32'(er[s]), 0);
`endif
    endtask

    // entered and left at a negedge with the instance idle and ready
    task automatic stream(input int s, input int w, input logic [9:0] d, input int r_exp,
                          input bit intrude);
        chk("ready_idle", 32'(rdy[s]), 1);
        dbus  = d;
        ld[s] = 1'b1;
        @(negedge clk);
        ld[s] = 1'b0;
        chk("clr_pulse", 32'(clr[s]), 1);
        chk("clr_ready", 32'(rdy[s]), 0);
        chk("clr_valid", 32'(bv[s]), 0);
        for (int i = 0; i < w; i++) begin
            @(negedge clk);
            chk("bit_valid", 32'(bv[s]), 1);
            chk("bit_val", 32'(bo[s]), 32'(d[i]));
            chk("bit_last", 32'(lst[s]), (i == w - 1) ? 1 : 0);
            chk("bit_ready", 32'(rdy[s]), 0);
            chk("bit_clr", 32'(clr[s]), 0);
            if (intrude && i == 2) begin
                ld[s] = 1'b1;
                dbus  = ~d;
            end else begin
                ld[s] = 1'b0;
            end
        end
        @(negedge clk);
        chk("done_pulse", 32'(dn[s]), 1);
        chk("done_valid", 32'(bv[s]), 0);
        chk("done_bit", 32'(bo[s]), 0);
        chk("done_ready", 32'(rdy[s]), 0);
        chk("residue", 32'(res[s]), 32'(r_exp));
`ifdef SERIALIZER_CHECK_EN
        chk("exp_residue", 32'(er[s]), 32'(r_exp));
`endif
        @(negedge clk);
        chk("post_done", 32'(dn[s]), 0);
        chk("post_ready", 32'(rdy[s]), 1);
    endtask

    initial begin
        rst   = 1'b1;
        ld    = 3'b000;
        abort = 1'b0;
        dbus  = '0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) chk_reset_vals(s);
        rst = 1'b0;
        @(negedge clk);

        // 858 = 10'b1101011010 -> 0,1,0,1,1,0,1,0,1,1 ; 858 mod 5 = 3
        stream(0, 10, 10'd858, 3, 1'b0);

        // W=5 back to back: 31 -> residue 1, then 0 -> residue 0
        stream(1, 5, 10'd31, 1, 1'b0);
        stream(1, 5, 10'd0, 0, 1'b0);

        // load pulsed mid-SHIFT with a different word must be ignored
        stream(0, 10, 10'd858, 3, 1'b1);

        // abort at 4th SHIFT cycle of 858
        dbus  = 10'd858;
        ld[0] = 1'b1;
        @(negedge clk);
        ld[0] = 1'b0;
        chk("ab_clr", 32'(clr[0]), 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("ab_valid", 32'(bv[0]), 1);
            if (i == 3) abort = 1'b1;
        end
        chk("ab_bit3", 32'(bo[0]), 1);
        @(negedge clk);
        abort = 1'b0;
        chk("ab_flush_clr", 32'(clr[0]), 1);
        chk("ab_flush_valid", 32'(bv[0]), 0);
        chk("ab_flush_done", 32'(dn[0]), 0);
        chk("ab_flush_last", 32'(lst[0]), 0);
        chk("ab_flush_ready", 32'(rdy[0]), 0);
        @(negedge clk);
        chk("ab_ready", 32'(rdy[0]), 1);
        chk("ab_clr_end", 32'(clr[0]), 0);
        chk("ab_no_done", 32'(dn[0]), 0);
        stream(0, 10, 10'd27, 2, 1'b0);

        // reset held 2 cycles mid-SHIFT
        dbus  = 10'd858;
        ld[0] = 1'b1;
        @(negedge clk);
        ld[0] = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_valid", 32'(bv[0]), 1);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals(0);
        @(negedge clk);
        chk_reset_vals(0);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_ready", 32'(rdy[0]), 1);
        chk("rel_clr", 32'(clr[0]), 0);
        chk("rel_done", 32'(dn[0]), 0);
        stream(0, 10, 10'd858, 3, 1'b0);

        // W=1
        stream(2, 1, 10'd1, 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
